// File: rtl/gpio_pkg.sv
// Shared register-map constants for the GPIO controller family.
package gpio_pkg;

    localparam int GPIO_AW = 4;

    localparam logic [GPIO_AW-1:0] GPIO_DATA       = 4'd0;
    localparam logic [GPIO_AW-1:0] GPIO_DIR        = 4'd1;
    localparam logic [GPIO_AW-1:0] GPIO_PIN        = 4'd2;
    localparam logic [GPIO_AW-1:0] GPIO_SET        = 4'd3;
    localparam logic [GPIO_AW-1:0] GPIO_CLR        = 4'd4;
    localparam logic [GPIO_AW-1:0] GPIO_TGL        = 4'd5;
    localparam logic [GPIO_AW-1:0] GPIO_RISE_EN    = 4'd6;
    localparam logic [GPIO_AW-1:0] GPIO_FALL_EN    = 4'd7;
    localparam logic [GPIO_AW-1:0] GPIO_IRQ_EN     = 4'd8;
    localparam logic [GPIO_AW-1:0] GPIO_IRQ_STATUS = 4'd9;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage synchroniser for the asynchronous pin inputs, plus raw
// (unmasked) edge detection against the previous synchronised sample.
module gpio_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] rise_raw,
    output logic [WIDTH-1:0] fall_raw
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];
    logic [WIDTH-1:0] prev_in;

    // Shift the pins through the synchroniser chain and keep one delayed copy
    // of the last stage for edge detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= '0;
            end
            prev_in <= '0;
        end else begin
            stages[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
            prev_in <= stages[SYNC_STAGES-1];
        end
    end

    assign sync_in  = stages[SYNC_STAGES-1];
    assign rise_raw = sync_in & ~prev_in;
    assign fall_raw = ~sync_in & prev_in;

endmodule

// File: rtl/gpio_ctrl_irq.sv
// Parametrised GPIO controller: data/direction registers with atomic
// SET/CLR/TGL, synchronised pin readback, per-pin edge capture into a sticky
// W1C status register and a single level interrupt.
module gpio_ctrl_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               sel,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [GPIO_AW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [WIDTH-1:0]   gpio_out,
    input  logic [WIDTH-1:0]   gpio_in,
    output logic               irq
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] irq_status_q;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise_raw;
    logic [WIDTH-1:0] fall_raw;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] pin_val;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             rd;
    logic             unused_wdata;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .resetn   (resetn),
        .pins     (gpio_in),
        .sync_in  (sync_in),
        .rise_raw (rise_raw),
        .fall_raw (fall_raw)
    );

    assign wr = sel & wr_en;
    assign rd = sel & rd_en;
    // Bits above WIDTH are simply dropped.
    assign wd = wdata[WIDTH-1:0];
    assign unused_wdata = ^wdata;

    // Pins driven as outputs never raise status.
    assign rise     = rise_raw & ~dir_q & rise_en_q;
    assign fall     = fall_raw & ~dir_q & fall_en_q;
    assign w1c_mask = (wr && addr == GPIO_IRQ_STATUS) ? wd : '0;
    assign pin_val  = (data_q & dir_q) | (sync_in & ~dir_q);
    assign irq      = |(irq_status_q & irq_en_q);

    // Software-visible configuration and data registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_q    <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_en_q  <= '0;
        end else if (wr) begin
            case (addr)
                GPIO_DATA:    data_q    <= wd;
                GPIO_DIR:     dir_q     <= wd;
                GPIO_SET:     data_q    <= data_q | wd;
                GPIO_CLR:     data_q    <= data_q & ~wd;
                GPIO_TGL:     data_q    <= data_q ^ wd;
                GPIO_RISE_EN: rise_en_q <= wd;
                GPIO_FALL_EN: fall_en_q <= wd;
                GPIO_IRQ_EN:  irq_en_q  <= wd;
                default: ;
            endcase
        end
    end

    // Sticky status: a hardware edge in the same cycle beats a W1C of that bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_status_q <= '0;
        end else begin
            irq_status_q <= (irq_status_q & ~w1c_mask) | rise | fall;
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            gpio_out <= '0;
        end else begin
            gpio_out <= data_q & dir_q;
        end
    end

    // Read mux on pre-write register values; write-only and unmapped read 0.
    always_comb begin
        rd_mux = '0;
        case (addr)
            GPIO_DATA:       rd_mux = 32'(data_q);
            GPIO_DIR:        rd_mux = 32'(dir_q);
            GPIO_PIN:        rd_mux = 32'(pin_val);
            GPIO_RISE_EN:    rd_mux = 32'(rise_en_q);
            GPIO_FALL_EN:    rd_mux = 32'(fall_en_q);
            GPIO_IRQ_EN:     rd_mux = 32'(irq_en_q);
            GPIO_IRQ_STATUS: rd_mux = 32'(irq_status_q);
            default:         rd_mux = '0;
        endcase
    end

    // Read data register holds between read strobes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl_irq.sv
// Self-checking bench for gpio_ctrl_irq: directed scenarios plus random bus
// and pin traffic against a transaction-level reference model.
module tb_gpio_ctrl_irq;

    localparam int NS  = 2;
    localparam int NS8 = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] gpio_in = '0;
    logic [31:0] rdata;
    logic [31:0] gpio_out;
    logic        irq;
    logic [31:0] rdata8;
    logic [7:0]  gpio_out8;
    logic        irq8;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_data, m_dir, m_rise, m_fall, m_ien, m_stat;
    logic [31:0] m_rdata, m_gout, m_prev;
    logic [31:0] in_q [$];

    always #5 clk = ~clk;

    gpio_ctrl_irq #(.WIDTH(32), .SYNC_STAGES(NS)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sel      (sel),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq)
    );

    gpio_ctrl_irq #(.WIDTH(8), .SYNC_STAGES(NS8)) dut8 (
        .clk      (clk),
        .resetn   (resetn),
        .sel      (sel),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata8),
        .gpio_out (gpio_out8),
        .gpio_in  (gpio_in[7:0]),
        .irq      (irq8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [3:0] a);
        case (a)
            4'd0:    return m_data;
            4'd1:    return m_dir;
            4'd2:    return (m_data & m_dir) | (in_q[0] & ~m_dir);
            4'd6:    return m_rise;
            4'd7:    return m_fall;
            4'd8:    return m_ien;
            4'd9:    return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = 0; m_dir = 0; m_rise = 0; m_fall = 0; m_ien = 0; m_stat = 0;
        m_rdata = 0; m_gout = 0; m_prev = 0;
        in_q.delete();
        repeat (NS) in_q.push_back(32'h0);
    endtask

    // One clock edge of the model, using the inputs the bench is holding.
    task automatic model_edge();
        logic [31:0] s_old, rs, fl, mask;
        if (!resetn) begin
            model_reset();
            return;
        end
        s_old = in_q[0];
        rs = s_old & ~m_prev & ~m_dir & m_rise;
        fl = ~s_old & m_prev & ~m_dir & m_fall;
        if (sel && rd_en) m_rdata = reg_value(addr);
        m_gout = m_data & m_dir;
        mask = 0;
        if (sel && wr_en) begin
            case (addr)
                4'd0: m_data = wdata;
                4'd1: m_dir  = wdata;
                4'd3: m_data = m_data | wdata;
                4'd4: m_data = m_data & ~wdata;
                4'd5: m_data = m_data ^ wdata;
                4'd6: m_rise = wdata;
                4'd7: m_fall = wdata;
                4'd8: m_ien  = wdata;
                4'd9: mask   = wdata;
                default: ;
            endcase
        end
        m_stat = (m_stat & ~mask) | rs | fl;
        m_prev = s_old;
        void'(in_q.pop_front());
        in_q.push_back(gpio_in);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("rdata", rdata, m_rdata);
        chk("gpio_out", gpio_out, m_gout);
        chk("irq", {31'b0, irq}, {31'b0, |(m_stat & m_ien)});
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1; wr_en = 1; rd_en = 0; addr = a; wdata = d;
        cycle();
        sel = 0; wr_en = 0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        sel = 1; rd_en = 1; wr_en = 0; addr = a;
        cycle();
        sel = 0; rd_en = 0;
        d = rdata;
    endtask

    initial begin
        logic [31:0] v;
        model_reset();

        // reset state
        resetn = 0;
        idle(2);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_gpio_out", gpio_out, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_rdata8", rdata8, 32'h0);
        resetn = 1;
        idle(1);
        for (int a = 0; a < 16; a++) begin
            bus_rd(4'(a), v);
            chk($sformatf("rst_read_%0d", a), v, 32'h0);
            chk($sformatf("rst_read8_%0d", a), rdata8, 32'h0);
        end

        // data path and atomic ops
        bus_wr(4'd1, 32'h0000_00FF);
        bus_wr(4'd0, 32'hA5A5_A5A5);
        chk("gout_before", gpio_out, 32'h0);
        idle(1);
        chk("gout_a5", gpio_out, 32'h0000_00A5);
        bus_wr(4'd3, 32'h0000_0F00);
        bus_rd(4'd0, v);
        chk("set", v, 32'hA5A5_AFA5);
        bus_wr(4'd4, 32'h0000_0005);
        bus_rd(4'd0, v);
        chk("clr", v, 32'hA5A5_AFA0);
        bus_wr(4'd5, 32'h0000_00FF);
        bus_rd(4'd0, v);
        chk("tgl", v, 32'hA5A5_AF5F);
        chk("tgl8", rdata8, 32'h0000_005F);
        idle(1);
        chk("gout_5f", gpio_out, 32'h0000_005F);
        chk("gout8_5f", {24'b0, gpio_out8}, 32'h0000_005F);
        bus_rd(4'd3, v);
        chk("set_reads0", v, 32'h0);

        // pin readback latency
        bus_wr(4'd1, 32'h0);
        gpio_in = 32'h0000_1234;
        for (int k = 1; k <= NS + 1; k++) begin
            bus_rd(4'd2, v);
            chk($sformatf("pin_edge_%0d", k), v, (k == NS + 1) ? 32'h1234 : 32'h0);
        end

        // rising edge capture and W1C
        gpio_in = 32'h0;
        idle(NS + 2);
        bus_wr(4'd7, 32'h0);
        bus_wr(4'd6, 32'h8);
        bus_wr(4'd8, 32'h8);
        bus_wr(4'd9, 32'hFFFF_FFFF);
        chk("irq_clear", {31'b0, irq}, 32'h0);
        gpio_in = 32'h8;
        for (int k = 1; k <= NS + 1; k++) begin
            cycle();
            chk($sformatf("irq_edge_%0d", k), {31'b0, irq}, (k == NS + 1) ? 32'h1 : 32'h0);
        end
        bus_rd(4'd9, v);
        chk("stat_rise", v, 32'h8);
        bus_wr(4'd9, 32'h0);
        chk("w1c_zero", {31'b0, irq}, 32'h1);
        bus_wr(4'd9, 32'h8);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        bus_rd(4'd9, v);
        chk("w1c_stat", v, 32'h0);
        gpio_in = 32'h0;
        idle(NS + 3);
        bus_rd(4'd9, v);
        chk("fall_disabled", v, 32'h0);

        // W1C colliding with a new rise on the same bit
        gpio_in = 32'h8;
        idle(NS);
        bus_wr(4'd9, 32'h8);
        chk("collide_irq", {31'b0, irq}, 32'h1);
        bus_rd(4'd9, v);
        chk("collide_stat", v, 32'h8);

        // narrow instance and unmapped address
        bus_wr(4'd0, 32'hFFFF_FFFF);
        bus_rd(4'd0, v);
        chk("data32_ff", v, 32'hFFFF_FFFF);
        chk("data8_ff", rdata8, 32'h0000_00FF);
        bus_rd(4'd12, v);
        chk("addr12", v, 32'h0);
        chk("addr12_8", rdata8, 32'h0);

        // reset in the middle of a read
        bus_wr(4'd1, 32'hFF);
        idle(1);
        sel = 1; rd_en = 1; addr = 4'd0; resetn = 0;
        cycle();
        sel = 0; rd_en = 0;
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_gout", gpio_out, 32'h0);
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        chk("midrst_rdata8", rdata8, 32'h0);
        chk("midrst_gout8", {24'b0, gpio_out8}, 32'h0);
        chk("midrst_irq8", {31'b0, irq8}, 32'h0);
        resetn = 1;
        gpio_in = 32'h0;
        idle(NS + 2);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sel    = ($urandom_range(3) != 0);
            wr_en  = ($urandom_range(1) != 0);
            rd_en  = ($urandom_range(1) != 0);
            addr   = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
            wdata  = $urandom;
            if ($urandom_range(3) == 0) gpio_in = $urandom;
            resetn = ($urandom_range(499) != 0);
            cycle();
        end
        resetn = 1; sel = 0; wr_en = 0; rd_en = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl_irq.md
# gpio_ctrl_irq

Parametrised GPIO controller, the successor to the fixed 32-bit GPIO block. It sits on the same simple sel/wr_en/rd_en register bus. Over the previous block it adds:
- configurable pin count;
- a multi-stage input synchroniser;
- atomic SET/CLR/TGL writes to the data register;
- per-pin rising/falling edge capture, with a sticky write-1-to-clear status and a single level interrupt to the CPU.

## Interface
Parameters:
- WIDTH, 32: number of GPIO pins, 1..32. Register bits above WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2: depth of the gpio_in synchroniser, minimum 2.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- sel  in  1  block selected.
- wr_en  in  1  write strobe, qualified by sel.
- rd_en  in  1  read strobe, qualified by sel.
- addr  in  4  word register index.
- wdata  in  32  write data.
- rdata  out  32  registered read data. Holds its value between reads.
- gpio_out  out  WIDTH  registered pin drive.
- gpio_in  in  WIDTH  asynchronous pin input.
- irq  out  1  level interrupt, equal to OR of (IRQ_STATUS & IRQ_EN).

## Operation
Register map (addr):
- 0 DATA: rw, output data.
- 1 DIR: rw, direction; 1 = output.
- 2 PIN: ro, value (DATA & DIR) | (sync_in & ~DIR).
- 3 SET: wo, DATA <= DATA | wdata.
- 4 CLR: wo, DATA <= DATA & ~wdata.
- 5 TGL: wo, DATA <= DATA ^ wdata.
- 6 RISE_EN: rw.
- 7 FALL_EN: rw.
- 8 IRQ_EN: rw.
- 9 IRQ_STATUS: rw1c.
- 10..15: read 0, writes ignored.
- Write-only registers (SET/CLR/TGL) read 0.

Edge capture:
- sync_in is the last synchroniser stage. prev_in is sync_in delayed one clock.
- rise = sync_in & ~prev_in & ~DIR & RISE_EN.
- fall = ~sync_in & prev_in & ~DIR & FALL_EN.
- Each cycle: IRQ_STATUS <= (IRQ_STATUS & ~w1c_mask) | rise | fall.
- A hardware set wins over a software clear of the same bit in the same cycle.
- IRQ_STATUS bits are sticky. Disabling RISE_EN/FALL_EN does not clear them; disabling IRQ_EN only masks irq.
- Pins configured as outputs never set status.

Bus:
- A write takes effect at the clock edge where sel & wr_en is high.
- rdata updates at the clock edge where sel & rd_en is high. Otherwise rdata holds.
- Simultaneous rd_en and wr_en to the same address returns the pre-write value.

## Timing
Reset (resetn low at a clock edge) clears the following to 0:
- every register: DATA, DIR, RISE_EN, FALL_EN, IRQ_EN, IRQ_STATUS;
- all synchroniser stages and prev_in;
- rdata, gpio_out and irq.

Latencies:
- gpio_out = DATA & DIR, registered. It reflects a DATA/DIR/SET/CLR/TGL write 2 clocks after the write edge: one cycle for the register update, one for the output register.
- Read latency: rdata is valid 1 clock after the sel & rd_en edge.
- gpio_in change → PIN readable after SYNC_STAGES edges.
- gpio_in change → IRQ_STATUS set, and irq high, SYNC_STAGES+1 edges after the change.

Boundary cases:
- A gpio_in pulse shorter than one clock may be missed. No guarantee is made.
- The first cycles after reset can produce a rise if gpio_in is high. Software must clear IRQ_STATUS after enabling edges.
- Writing IRQ_STATUS with zeros has no effect.
- A W1C to a bit with no simultaneous event clears it, and irq falls the following edge.
- Reset mid-operation aborts any pending read; rdata = 0.

## Structure
- Package gpio_pkg holds:
  - address localparams: GPIO_DATA, GPIO_DIR, GPIO_PIN, GPIO_SET, GPIO_CLR, GPIO_TGL, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_IRQ_EN, GPIO_IRQ_STATUS;
  - the 4-bit address width constant.
- Sub-module gpio_sync_edge (params WIDTH, SYNC_STAGES):
  - inputs clk, resetn, async vector;
  - outputs sync_in, rise_raw, fall_raw (unmasked).
- The top level keeps registers, masking, the status update, the read mux and irq.

## Test plan
- Reset, then read every address → all read 0; gpio_out = 0, irq = 0.
- Write DIR = 0x0000_00FF, DATA = 0xA5A5_A5A5; gpio_out = 0x0000_00A5 two clocks later. SET 0x0F00 → DATA reads 0xA5A5_AFA5. CLR 0x5 → DATA reads 0xA5A5_AFA0. TGL 0xFF → DATA reads 0xA5A5_AF5F; gpio_out = 0x5F.
- DIR = 0, gpio_in = 0x0000_1234 → PIN reads 0x1234 after SYNC_STAGES edges; no earlier read returns it.
- RISE_EN = bit 3, IRQ_EN = bit 3; gpio_in[3] 0→1 → IRQ_STATUS = 0x8 and irq = 1 exactly SYNC_STAGES+1 edges later. W1C 0x8 → status 0, irq 0 next edge. A falling edge with FALL_EN = 0 sets nothing.
- W1C of bit 3 in the same cycle a new rise on bit 3 is captured → bit 3 stays 1 and irq stays high.
- WIDTH = 8 instance: write DATA = 0xFFFF_FFFF → reads 0x0000_00FF. Addr 12 read → 0. Reset asserted mid-sequence → all outputs 0 the next edge.
